// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, owner and wait-counter definitions for the memory bus arbiter
package mem_arb_pkg;

   localparam int WAIT_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      DMA_ACC = 2'd2,
      TURN    = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   function automatic owner_t other_owner(input owner_t own);
      return (own == OWN_DMA) ? OWN_CPU : OWN_DMA;
   endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// rtl/mem_arb_wait_cnt.sv - wait-state down-counter with load, decrement and last-cycle flag
module mem_arb_wait_cnt
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              dec,
   output logic [WAIT_W-1:0] count,
   output logic              last
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WAIT_W'(1);
      end
   end

   assign last = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA single-port memory arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_n_oe,
   input  logic              cpu_n_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_n_rdy,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_n_cs,
   output logic              mem_n_oe,
   output logic              mem_n_we,
   output logic              d_sel
);

   localparam logic [WAIT_W-1:0] WAIT_LD    = WAIT_W'(WAIT_CYCLES);
   localparam logic              FIRST_LAST = (WAIT_CYCLES == 0);

   arb_state_t        state;
   owner_t            turn_to;
   logic              cpu_req;
   logic              cpu_wr;
   logic              cpu_done;
   logic              in_acc;
   logic              start;
   owner_t            start_own;
   owner_t            cur_own;
   owner_t            win;
   logic              other_pending;
   logic              start_wr;
   logic [ADDR_W-1:0] start_addr;
   logic              cnt_dec;
   logic              cnt_last;
   logic [WAIT_W-1:0] cnt_val;

   assign cpu_req = !cpu_n_oe || !cpu_n_we;
   assign cpu_wr  = !cpu_n_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_t last_owner;

   always_comb begin
      win = OWN_DMA;
      if (cpu_req && dma_req) begin
         win = other_owner(last_owner);
      end else if (cpu_req) begin
         win = OWN_CPU;
      end
   end
`else
   always_comb begin
      win = OWN_DMA;
      if (cpu_req && !dma_req) begin
         win = OWN_CPU;
      end
   end
`endif

   // An access starts from IDLE on any request, or unconditionally after TURN.
   always_comb begin
      start     = 1'b0;
      start_own = win;
      if ((state == IDLE) && (cpu_req || dma_req)) begin
         start = 1'b1;
      end else if (state == TURN) begin
         start     = 1'b1;
         start_own = turn_to;
      end
   end

   assign in_acc        = (state == CPU_ACC) || (state == DMA_ACC);
   assign cur_own       = (state == DMA_ACC) ? OWN_DMA : OWN_CPU;
   assign other_pending = (cur_own == OWN_DMA) ? cpu_req : dma_req;
   assign start_wr      = (start_own == OWN_DMA) ? dma_we : cpu_wr;
   assign start_addr    = (start_own == OWN_DMA) ? dma_addr : cpu_addr;
   assign cnt_dec       = in_acc && !cnt_last;

   mem_arb_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (start),
      .load_val (WAIT_LD),
      .dec      (cnt_dec),
      .count    (cnt_val),
      .last     (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         turn_to  <= OWN_CPU;
         mem_addr <= '0;
         mem_n_cs <= 1'b1;
         mem_n_oe <= 1'b1;
         mem_n_we <= 1'b1;
         dma_gnt  <= 1'b0;
         d_sel    <= 1'b0;
         dma_done <= 1'b0;
         cpu_done <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_owner <= OWN_DMA;
`endif
      end else begin
         dma_done <= 1'b0;
         cpu_done <= 1'b0;
         if (start) begin
            state    <= (start_own == OWN_DMA) ? DMA_ACC : CPU_ACC;
            mem_addr <= start_addr;
            mem_n_cs <= 1'b0;
            mem_n_oe <= start_wr;
            mem_n_we <= !start_wr;
            dma_gnt  <= (start_own == OWN_DMA);
            d_sel    <= (start_own == OWN_DMA);
            dma_done <= (start_own == OWN_DMA) && FIRST_LAST;
            cpu_done <= (start_own == OWN_CPU) && FIRST_LAST;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= start_own;
`endif
         end else if (in_acc) begin
            if (cnt_last) begin
               mem_n_cs <= 1'b1;
               mem_n_oe <= 1'b1;
               mem_n_we <= 1'b1;
               dma_gnt  <= 1'b0;
               d_sel    <= 1'b0;
               if (other_pending) begin
                  state   <= TURN;
                  turn_to <= other_owner(cur_own);
               end else begin
                  state <= IDLE;
               end
            end else begin
               // Completion flags are registered one cycle ahead of the final count.
               dma_done <= (cur_own == OWN_DMA) && (cnt_val == WAIT_W'(1));
               cpu_done <= (cur_own == OWN_CPU) && (cnt_val == WAIT_W'(1));
            end
         end
      end
   end

   assign cpu_n_rdy = cpu_req && !cpu_done;

endmodule
